// File: rtl/boron_key_sched_seq.sv
// Sequential Boron key scheduler: streams round keys K0..K(NUM_ROUNDS) over valid/ready,
// either forward (generated on the fly) or reversed (replayed from a buffer after expansion).
module boron_key_sched_seq #(
  parameter int unsigned KEY_W      = 80,
  parameter int unsigned NUM_ROUNDS = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             mode_i,
  input  logic [KEY_W-1:0] key_in_i,
  output logic             busy_o,
  output logic             rk_valid_o,
  input  logic             rk_ready_i,
  output logic [63:0]      rk_data_o,
  output logic [4:0]       rk_index_o,
  output logic             rk_last_o,
  output logic             done_o
);

  if (!(KEY_W == 80 || KEY_W == 128)) begin : gen_key_w_err
    $error("boron_key_sched_seq: KEY_W must be 80 or 128");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : gen_rounds_err
    $error("boron_key_sched_seq: NUM_ROUNDS must be in 1..31");
  end

  localparam logic [4:0] LastIdx = 5'(NUM_ROUNDS);
  // Nibble x of the S-box lives at bits [63-4x -: 4].
  localparam logic [63:0] SboxTab = 64'hE4B1_79CA_D20F_8536;

  typedef enum logic [2:0] {StIdle, StEnc, StExpand, StDec, StFin} state_e;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [4:0]       idx_q, idx_d;
  logic             buf_we;
  logic [63:0]      kbuf_q [NUM_ROUNDS+1];

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SboxTab[63 - 4 * int'(x) -: 4];
  endfunction

  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                   input logic [4:0]       c);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};
    r[3:0] = sbox(r[3:0]);
    if (KEY_W == 128) begin
      r[7:4] = sbox(r[7:4]);
    end
    r[63:59] = r[63:59] ^ c;
    return r;
  endfunction

  // State, key register, index and replay buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      key_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        kbuf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      if (buf_we) begin
        kbuf_q[idx_q] <= key_q[63:0];
      end
    end
  end

  // Next-state logic: load acceptance, key updates, index stepping.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    buf_we  = 1'b0;
    unique case (state_q)
      StIdle, StFin: begin
        // FIN accepts a load exactly like IDLE so back-to-back runs lose no cycle.
        if (load_i) begin
          state_d = mode_i ? StExpand : StEnc;
          key_d   = key_in_i;
          idx_d   = '0;
        end else if (state_q == StFin) begin
          state_d = StIdle;
        end
      end
      StEnc: begin
        if (rk_ready_i) begin
          if (idx_q == LastIdx) begin
            state_d = StFin;
          end else begin
            key_d = key_update(key_q, idx_q + 5'd1);
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StExpand: begin
        buf_we = 1'b1;
        key_d  = key_update(key_q, idx_q + 5'd1);
        if (idx_q == LastIdx) begin
          state_d = StDec;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      StDec: begin
        if (rk_ready_i) begin
          if (idx_q == 5'd0) begin
            state_d = StFin;
          end else begin
            idx_d = idx_q - 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded purely from registered state; rk_ready never reaches rk_valid.
  always_comb begin
    busy_o     = (state_q == StEnc) || (state_q == StExpand) || (state_q == StDec);
    rk_valid_o = (state_q == StEnc) || (state_q == StDec);
    done_o     = (state_q == StFin);
    rk_data_o  = '0;
    rk_index_o = '0;
    rk_last_o  = 1'b0;
    if (state_q == StEnc) begin
      rk_data_o  = key_q[63:0];
      rk_index_o = idx_q;
      rk_last_o  = (idx_q == LastIdx);
    end else if (state_q == StDec) begin
      rk_data_o  = kbuf_q[idx_q];
      rk_index_o = idx_q;
      rk_last_o  = (idx_q == 5'd0);
    end
  end

endmodule

// File: tb/tb_boron_key_sched_seq.sv
// Directed bench for boron_key_sched_seq (80-bit instance plus a 128-bit instance).
module tb_boron_key_sched_seq;

  localparam int NR = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, mode, rk_ready;
  logic [79:0] key_in;
  logic        busy, rk_valid, rk_last, done;
  logic [63:0] rk_data;
  logic [4:0]  rk_index;

  logic         load_b, ready_b;
  logic [127:0] key_b;
  logic         busy_b, valid_b, last_b, done_b;
  logic [63:0]  data_b;
  logic [4:0]   idx_b;

  boron_key_sched_seq #(.KEY_W(80), .NUM_ROUNDS(NR)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .mode_i(mode), .key_in_i(key_in),
    .busy_o(busy), .rk_valid_o(rk_valid), .rk_ready_i(rk_ready), .rk_data_o(rk_data),
    .rk_index_o(rk_index), .rk_last_o(rk_last), .done_o(done)
  );

  boron_key_sched_seq #(.KEY_W(128), .NUM_ROUNDS(NR)) dut_b (
    .clk_i(clk), .rst_i(rst), .load_i(load_b), .mode_i(1'b0), .key_in_i(key_b),
    .busy_o(busy_b), .rk_valid_o(valid_b), .rk_ready_i(ready_b), .rk_data_o(data_b),
    .rk_index_o(idx_b), .rk_last_o(last_b), .done_o(done_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  sbt [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                            4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  logic [63:0] exp_k [NR+1];
  logic [63:0] enc_keys [NR+1];
  logic [63:0] got_d [$];
  logic [4:0]  got_i [$];
  logic        got_l [$];
  int          first_valid, done_cyc, stab_err;
  bit          timed_out;

  function automatic logic [79:0] upd80(input logic [79:0] k, input int c);
    logic [79:0] r;
    r = {k[66:0], k[79:67]};
    r[3:0] = sbt[r[3:0]];
    r[63:59] = r[63:59] ^ 5'(c);
    return r;
  endfunction

  task automatic gen_exp(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    exp_k[0] = k[63:0];
    for (int i = 1; i <= NR; i++) begin
      k = upd80(k, i);
      exp_k[i] = k[63:0];
    end
  endtask

  task automatic do_load(input logic [79:0] key, input logic m);
    key_in = key;
    mode   = m;
    load   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Runs from cycle t+1 (n=1) until done; optionally pulses a junk load at cycle inj_n.
  task automatic collect(input int ready_pct, input int inj_n, input int budget);
    logic        stall;
    logic [63:0] pd;
    logic [4:0]  pi;
    logic        pl;
    got_d.delete(); got_i.delete(); got_l.delete();
    first_valid = -1; done_cyc = -1; stab_err = 0; timed_out = 1'b1; stall = 1'b0;
    pd = '0; pi = '0; pl = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      load = (n == inj_n);
      if (n == inj_n) begin
        key_in = 80'hFFFF_0000_FFFF_0000_FFFF;
        mode   = ~mode;
      end
      rk_ready = ($urandom_range(99) < ready_pct);
      if (rk_valid && first_valid < 0) first_valid = n;
      if (stall && (!rk_valid || rk_data !== pd || rk_index !== pi || rk_last !== pl))
        stab_err++;
      stall = rk_valid && !rk_ready;
      pd = rk_data; pi = rk_index; pl = rk_last;
      if (rk_valid && rk_ready) begin
        got_d.push_back(rk_data); got_i.push_back(rk_index); got_l.push_back(rk_last);
      end
      if (done) begin
        done_cyc  = n;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; mode = 1'b0; rk_ready = 1'b0; key_in = '0;
    load_b = 1'b0; ready_b = 1'b0; key_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, rk_valid, rk_last, done} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, rk_valid, rk_last, done});
    end
    n_cmp++;
    if (rk_data !== 64'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", rk_data);
    end
    n_cmp++;
    if (rk_index !== 5'd0) begin
      n_bad++; $display("FAIL reset_index: got %0d want 0", rk_index);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, rk_valid, done} !== 3'b000) begin
      n_bad++; $display("FAIL idle_hold: got %b want 000", {busy, rk_valid, done});
    end
  endtask

  task automatic test_enc_zero;
    int bad;
    gen_exp(80'h0);
    do_load(80'h0, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL enc_busy: got %b want 1", busy);
    end
    collect(100, 0, 100);
    n_cmp++;
    if (timed_out || got_d.size() != NR + 1) begin
      n_bad++; $display("FAIL enc_count: got %0d keys (timeout %0d) want %0d",
                        got_d.size(), timed_out, NR + 1);
      return;
    end
    n_cmp++;
    if (first_valid != 1) begin
      n_bad++; $display("FAIL enc_latency: got %0d want 1", first_valid);
    end
    n_cmp++;
    if (got_d[0] !== 64'h0 || got_i[0] !== 5'd0) begin
      n_bad++; $display("FAIL enc_k0: got %h@%0d want 0@0", got_d[0], got_i[0]);
    end
    n_cmp++;
    if (got_d[1] !== 64'h0800_0000_0000_000E || got_i[1] !== 5'd1) begin
      n_bad++; $display("FAIL enc_k1: got %h@%0d want 080000000000000e@1", got_d[1], got_i[1]);
    end
    bad = 0;
    for (int i = 0; i <= NR; i++) begin
      enc_keys[i] = got_d[i];
      if (got_d[i] !== exp_k[i] || got_i[i] !== 5'(i) || got_l[i] !== (i == NR)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL enc_seq: got %0d bad entries want 0", bad);
    end
    n_cmp++;
    if (done_cyc != NR + 2) begin
      n_bad++; $display("FAIL enc_done: got cycle %0d want %0d", done_cyc, NR + 2);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL enc_after_done: got %b want 00", {busy, done});
    end
  endtask

  task automatic test_enc_128;
    key_b = '0; ready_b = 1'b1; load_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_b = 1'b0;
    n_cmp++;
    if (valid_b !== 1'b1 || data_b !== 64'h0 || idx_b !== 5'd0) begin
      n_bad++; $display("FAIL k128_k0: got v%b %h@%0d want v1 0@0", valid_b, data_b, idx_b);
    end
    @(negedge clk);
    n_cmp++;
    if (data_b !== 64'h0800_0000_0000_00EE || idx_b !== 5'd1) begin
      n_bad++; $display("FAIL k128_k1: got %h@%0d want 08000000000000ee@1", data_b, idx_b);
    end
    for (int n = 0; n < 40 && !done_b; n++) @(negedge clk);
    n_cmp++;
    if (done_b !== 1'b1) begin
      n_bad++; $display("FAIL k128_done: got %b want 1", done_b);
    end
    @(negedge clk);
  endtask

  task automatic test_dec;
    int bad;
    do_load(80'h0, 1'b1);
    collect(100, 0, 200);
    n_cmp++;
    if (timed_out || got_d.size() != NR + 1) begin
      n_bad++; $display("FAIL dec_count: got %0d keys (timeout %0d) want %0d",
                        got_d.size(), timed_out, NR + 1);
      return;
    end
    n_cmp++;
    if (first_valid != NR + 2) begin
      n_bad++; $display("FAIL dec_latency: got %0d want %0d", first_valid, NR + 2);
    end
    bad = 0;
    for (int j = 0; j <= NR; j++) begin
      if (got_d[j] !== enc_keys[NR-j] || got_i[j] !== 5'(NR - j) || got_l[j] !== (j == NR))
        bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL dec_seq: got %0d bad entries want 0", bad);
    end
    n_cmp++;
    if (done_cyc != 2 * NR + 3) begin
      n_bad++; $display("FAIL dec_done: got cycle %0d want %0d", done_cyc, 2 * NR + 3);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [79:0] k;
    logic        m;
    int          bad;
    for (int r = 0; r < 40; r++) begin
      k[79:64] = 16'($urandom);
      k[63:32] = $urandom;
      k[31:0]  = $urandom;
      m = r[0];
      gen_exp(k);
      do_load(k, m);
      collect(50, 0, 3000);
      bad = (got_d.size() != NR + 1) ? 1 : 0;
      for (int j = 0; j < got_d.size() && j <= NR; j++) begin
        if (got_d[j] !== (m ? exp_k[NR-j] : exp_k[j])) bad++;
      end
      n_cmp++;
      if (timed_out || bad != 0 || stab_err != 0) begin
        n_bad++; $display("FAIL bp_run%0d: mode %b timeout %0d bad %0d unstable %0d want 0/0/0",
                          r, m, timed_out, bad, stab_err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_ignored;
    int bad;
    logic [79:0] k;
    k = 80'h0123_4567_89AB_CDEF_0123;
    gen_exp(k);
    do_load(k, 1'b0);
    collect(100, 8, 100);
    bad = (got_d.size() != NR + 1) ? 1 : 0;
    for (int j = 0; j < got_d.size() && j <= NR; j++) if (got_d[j] !== exp_k[j]) bad++;
    n_cmp++;
    if (bad != 0 || done_cyc != NR + 2) begin
      n_bad++; $display("FAIL ign_enc: bad %0d done %0d want 0 / %0d", bad, done_cyc, NR + 2);
    end
    @(negedge clk);
    do_load(k, 1'b1);
    collect(100, 5, 200);
    bad = (got_d.size() != NR + 1) ? 1 : 0;
    for (int j = 0; j < got_d.size() && j <= NR; j++) if (got_d[j] !== exp_k[NR-j]) bad++;
    n_cmp++;
    if (bad != 0 || done_cyc != 2 * NR + 3) begin
      n_bad++; $display("FAIL ign_dec: bad %0d done %0d want 0 / %0d", bad, done_cyc, 2 * NR + 3);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    bit found;
    int bad;
    found = 1'b0;
    do_load(80'h0123_4567_89AB_CDEF_0123, 1'b1);
    rk_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (rk_valid && rk_index == 5'd10) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL rst_reach: got no index 10 want index 10");
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, rk_valid, rk_last, done} !== 4'b0000 || rk_data !== 64'h0 ||
        rk_index !== 5'd0) begin
      n_bad++; $display("FAIL rst_mid_outs: got %b %h %0d want 0000 0 0",
                        {busy, rk_valid, rk_last, done}, rk_data, rk_index);
    end
    gen_exp(80'h0);
    do_load(80'h0, 1'b0);
    collect(100, 0, 100);
    bad = (got_d.size() != NR + 1) ? 1 : 0;
    for (int j = 0; j < got_d.size() && j <= NR; j++)
      if (got_d[j] !== exp_k[j] || got_i[j] !== 5'(j)) bad++;
    n_cmp++;
    if (bad != 0 || first_valid != 1 || done_cyc != NR + 2) begin
      n_bad++; $display("FAIL rst_restart: bad %0d first %0d done %0d want 0 1 %0d",
                        bad, first_valid, done_cyc, NR + 2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_enc_zero();
    test_enc_128();
    test_dec();
    test_load_ignored();
    test_backpressure();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
